// File: rtl/chord_mixer.sv
// N-voice sample mixer: collects one sample per active voice, sums one voice per cycle, then saturates or shift-scales.
// Latency: sample_valid NUM_VOICES+1 cycles after the last ready; a request arriving while busy is dropped and flagged as overrun.
module chord_mixer #(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = 16,
    parameter int TIMEOUT      = 64,
    parameter int SHIFT_MODE   = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               generate_next_sample,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
    input  logic [NUM_VOICES-1:0]              voice_ready,
    input  logic [NUM_VOICES-1:0]              voice_active,
    output logic [SAMPLE_WIDTH-1:0]            sample_out,
    output logic                               sample_valid,
    output logic                               timeout_flag,
    output logic                               overrun
);
    localparam int CL = $clog2(NUM_VOICES);
    localparam int AW = SAMPLE_WIDTH + CL + 1;
    localparam int IW = (NUM_VOICES > 1) ? CL : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COLLECT, SUM, OUT} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [NUM_VOICES-1:0]          act_mask;
    logic [NUM_VOICES-1:0]          got_mask;
    logic [NUM_VOICES-1:0]          cap;
    logic signed [SAMPLE_WIDTH-1:0] lat [NUM_VOICES];
    logic signed [AW-1:0]           acc;
    logic signed [AW-1:0]           addend;
    logic signed [AW-1:0]           acc_nxt;
    logic [SAMPLE_WIDTH-1:0]        cond;
    logic [IW-1:0]                  idx;
    logic [TW-1:0]                  tcnt;
    logic                           timed_out;
    logic                           covered;
    logic                           tmo_hit;
    logic                           last_idx;

    // The request cycle captures with the incoming active mask, since act_mask is not yet loaded.
    always_comb begin
        cap = '0;
        if (state == IDLE && generate_next_sample) begin
            cap = voice_ready & voice_active;
        end else if (state == COLLECT) begin
            cap = voice_ready & act_mask;
        end
    end

    assign covered  = (((got_mask | cap) & act_mask) == act_mask);
    assign tmo_hit  = (tcnt == TW'(TIMEOUT - 1));
    assign last_idx = (idx == IW'(NUM_VOICES - 1));
    assign addend   = got_mask[idx] ? {{(AW-SAMPLE_WIDTH){lat[idx][SAMPLE_WIDTH-1]}}, lat[idx]} : '0;
    assign acc_nxt  = acc + addend;

    generate
        if (SHIFT_MODE == 0) begin : g_sat
            always_comb begin
                if (acc_nxt > SAT_MAX) begin
                    cond = SAT_MAX[SAMPLE_WIDTH-1:0];
                end else if (acc_nxt < SAT_MIN) begin
                    cond = SAT_MIN[SAMPLE_WIDTH-1:0];
                end else begin
                    cond = acc_nxt[SAMPLE_WIDTH-1:0];
                end
            end
        end else begin : g_shift
            assign cond = SAMPLE_WIDTH'(acc_nxt >>> CL);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sample_valid = 1'b0;
        timeout_flag = 1'b0;
        case (state)
            IDLE:    if (generate_next_sample) state_nxt = COLLECT;
            COLLECT: if (covered || tmo_hit) state_nxt = SUM;
            SUM:     if (last_idx) state_nxt = OUT;
            OUT: begin
                state_nxt    = IDLE;
                sample_valid = 1'b1;
                timeout_flag = timed_out;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_mask   <= '0;
            got_mask   <= '0;
            acc        <= '0;
            idx        <= '0;
            tcnt       <= '0;
            timed_out  <= 1'b0;
            sample_out <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                lat[i] <= '0;
            end
        end else begin
            overrun <= generate_next_sample && (state != IDLE);
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (cap[i]) begin
                    lat[i] <= voice_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                end
            end
            case (state)
                IDLE: begin
                    if (generate_next_sample) begin
                        act_mask  <= voice_active;
                        got_mask  <= cap;
                        tcnt      <= '0;
                        idx       <= '0;
                        acc       <= '0;
                        timed_out <= 1'b0;
                    end
                end
                COLLECT: begin
                    got_mask <= got_mask | cap;
                    if (!covered) begin
                        if (tmo_hit) begin
                            timed_out <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                SUM: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                    // Register the conditioned result with the final add so it is stable during OUT.
                    if (last_idx) begin
                        sample_out <= cond;
                    end
                end
                OUT: begin
                    acc       <= '0;
                    timed_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chord_mixer.sv
// Bench for chord_mixer: a saturating and a shift-scaling instance share the stimulus; frames are
// predicted from per-voice ready times and samples using plain integer arithmetic.
module tb_chord_mixer;
    localparam int NV = 3;
    localparam int SW = 16;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              gen = 1'b0;
    logic [NV*SW-1:0]  vs = '0;
    logic [NV-1:0]     vr = '0;
    logic [NV-1:0]     va = '0;
    logic [SW-1:0]     so_a, so_b;
    logic              sv_a, sv_b, tf_a, tf_b, ov_a, ov_b;

    int checks = 0;
    int errors = 0;

    int                 fr_d   [NV];
    int                 fr_d2  [NV];
    logic signed [SW-1:0] fr_s [NV];
    logic signed [SW-1:0] fr_s2[NV];
    logic [NV-1:0]      fr_act;
    int                 fr_extra;

    chord_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .TIMEOUT(TO), .SHIFT_MODE(0)) dut_sat (
        .clk(clk), .reset_n(reset_n), .generate_next_sample(gen), .voice_samples(vs),
        .voice_ready(vr), .voice_active(va), .sample_out(so_a), .sample_valid(sv_a),
        .timeout_flag(tf_a), .overrun(ov_a));

    chord_mixer #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .TIMEOUT(TO), .SHIFT_MODE(1)) dut_shf (
        .clk(clk), .reset_n(reset_n), .generate_next_sample(gen), .voice_samples(vs),
        .voice_ready(vr), .voice_active(va), .sample_out(so_b), .sample_valid(sv_b),
        .timeout_flag(tf_b), .overrun(ov_b));

    always #5 clk = ~clk;

    task automatic setup(input logic [NV-1:0] act, input int s0, input int s1, input int s2,
                         input int d0, input int d1, input int d2);
        fr_act = act;
        fr_s[0] = SW'(s0); fr_s[1] = SW'(s1); fr_s[2] = SW'(s2);
        fr_d[0] = d0; fr_d[1] = d1; fr_d[2] = d2;
        for (int i = 0; i < NV; i++) begin
            fr_d2[i] = -1;
            fr_s2[i] = '0;
        end
        fr_extra = -1;
    endtask

    // j counts cycles from the request cycle (j = 0); outputs seen at negedge j belong to cycle j.
    task automatic run_frame(input string name);
        int sum, tlast, t_eff, exp_lat, exp_sat, exp_sh, exp_ocnt;
        int vcnt_a, vcnt_b, seen_a, seen_b, ocnt;
        bit miss;
        logic [SW-1:0] got_a, got_b, e_a, e_b;
        logic got_to_a, got_to_b;
        miss = 0; tlast = 1; sum = 0;
        for (int i = 0; i < NV; i++) begin
            if (fr_act[i]) begin
                if (fr_d[i] < 0 || fr_d[i] > TO) miss = 1;
                else if (fr_d[i] > tlast) tlast = fr_d[i];
            end
        end
        t_eff = miss ? TO : tlast;
        for (int i = 0; i < NV; i++) begin
            if (fr_act[i] && fr_d[i] >= 0 && fr_d[i] <= t_eff) begin
                if (fr_d2[i] > fr_d[i] && fr_d2[i] <= t_eff) sum += int'(fr_s2[i]);
                else sum += int'(fr_s[i]);
            end
        end
        exp_lat  = t_eff + NV + 1;
        exp_sat  = (sum > 32767) ? 32767 : ((sum < -32768) ? -32768 : sum);
        exp_sh   = sum >>> 2;
        e_a      = SW'(exp_sat);
        e_b      = SW'(exp_sh);
        exp_ocnt = (fr_extra > 0) ? 1 : 0;
        vcnt_a = 0; vcnt_b = 0; seen_a = -1; seen_b = -1; ocnt = 0;
        got_a = '0; got_b = '0; got_to_a = 1'b0; got_to_b = 1'b0;
        for (int j = 0; j <= exp_lat + 5; j++) begin
            @(negedge clk);
            if (j > 0) begin
                if (sv_a) begin
                    vcnt_a++;
                    if (seen_a < 0) begin seen_a = j; got_a = so_a; got_to_a = tf_a; end
                end
                if (sv_b) begin
                    vcnt_b++;
                    if (seen_b < 0) begin seen_b = j; got_b = so_b; got_to_b = tf_b; end
                end
                if (ov_a) ocnt++;
            end
            gen = (j == 0) || (j == fr_extra);
            va  = (j == 0) ? fr_act : NV'($urandom);
            for (int i = 0; i < NV; i++) begin
                vr[i] = (j == fr_d[i]) || (j == fr_d2[i]);
                if (j == fr_d[i]) vs[i*SW +: SW] = fr_s[i];
                else if (j == fr_d2[i]) vs[i*SW +: SW] = fr_s2[i];
                else vs[i*SW +: SW] = SW'($urandom);
            end
            if (j >= exp_lat + 2) vr = NV'($urandom);
        end
        gen = 1'b0;
        vr  = '0;
        checks += 10;
        if (vcnt_a !== 1) begin errors++; $display("FAIL %s valid_count_sat: got %0d want 1", name, vcnt_a); end
        if (vcnt_b !== 1) begin errors++; $display("FAIL %s valid_count_shf: got %0d want 1", name, vcnt_b); end
        if (seen_a !== exp_lat) begin errors++; $display("FAIL %s latency_sat: got %0d want %0d", name, seen_a, exp_lat); end
        if (seen_b !== exp_lat) begin errors++; $display("FAIL %s latency_shf: got %0d want %0d", name, seen_b, exp_lat); end
        if (got_a !== e_a) begin errors++; $display("FAIL %s out_sat: got %0d want %0d", name, $signed(got_a), $signed(e_a)); end
        if (got_b !== e_b) begin errors++; $display("FAIL %s out_shf: got %0d want %0d", name, $signed(got_b), $signed(e_b)); end
        if (got_to_a !== miss) begin errors++; $display("FAIL %s timeout_sat: got %0b want %0b", name, got_to_a, miss); end
        if (got_to_b !== miss) begin errors++; $display("FAIL %s timeout_shf: got %0b want %0b", name, got_to_b, miss); end
        if (ocnt !== exp_ocnt) begin errors++; $display("FAIL %s overrun_count: got %0d want %0d", name, ocnt, exp_ocnt); end
        if (ov_b !== 1'b0) begin errors++; $display("FAIL %s overrun_shf_idle: got %0b want 0", name, ov_b); end
    endtask

    task automatic test_reset;
        #1;
        checks += 5;
        if (so_a !== '0) begin errors++; $display("FAIL reset_out_sat: got %0h want 0", so_a); end
        if (so_b !== '0) begin errors++; $display("FAIL reset_out_shf: got %0h want 0", so_b); end
        if (sv_a !== 1'b0 || sv_b !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b%0b want 00", sv_a, sv_b); end
        if (tf_a !== 1'b0 || tf_b !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b%0b want 00", tf_a, tf_b); end
        if (ov_a !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b%0b want 00", ov_a, ov_b); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        setup(3'b111, 1000, 2000, -500, 1, 1, 1);
        run_frame("basic");
        setup(3'b111, 1000, 2000, -500, 0, 3, 2);
        run_frame("basic_staggered");
    endtask

    task automatic test_saturation;
        setup(3'b111, 20000, 20000, 20000, 1, 2, 1);
        run_frame("sat_pos");
        setup(3'b111, -20000, -20000, -20000, 2, 1, 1);
        run_frame("sat_neg");
    endtask

    task automatic test_mask;
        setup(3'b101, 100, 30000, 100, 1, 1, 1);
        run_frame("mask_101");
    endtask

    task automatic test_overwrite;
        setup(3'b111, 111, 222, 333, 1, 3, 4);
        fr_d2[0] = 2;
        fr_s2[0] = SW'(-7000);
        run_frame("repeat_ready");
    endtask

    task automatic test_timeout;
        setup(3'b111, 1234, -4321, 9999, 2, 3, -1);
        run_frame("timeout");
    endtask

    task automatic test_overrun;
        setup(3'b111, 300, 400, 500, 1, 2, 3);
        fr_extra = 3 + NV - 1;
        run_frame("overrun");
        setup(3'b011, 300, 400, 500, 1, 1, 1);
        run_frame("after_overrun");
    endtask

    task automatic test_reset_mid;
        int pulses;
        @(negedge clk);
        gen = 1'b1; va = '1; vr = '0;
        @(negedge clk);
        gen = 1'b0; vr = 3'b001; vs = NV*SW'($urandom);
        @(negedge clk);
        vr = '0;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (so_a !== '0 || so_b !== '0) begin errors++; $display("FAIL midreset_out: got %0h/%0h want 0", so_a, so_b); end
        if (sv_a !== 1'b0 || sv_b !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b%0b want 00", sv_a, sv_b); end
        if (tf_a !== 1'b0 || tf_b !== 1'b0) begin errors++; $display("FAIL midreset_timeout: got %0b%0b want 00", tf_a, tf_b); end
        if (ov_a !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL midreset_overrun: got %0b%0b want 00", ov_a, ov_b); end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            vr = NV'($urandom);
            if (sv_a || sv_b) pulses++;
        end
        vr = '0;
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midreset_no_valid: got %0d pulses want 0", pulses); end
        setup(3'b000, 5000, 6000, 7000, 1, 1, 1);
        run_frame("empty_mask");
    endtask

    task automatic test_random;
        for (int n = 0; n < 20; n++) begin
            fr_act = NV'($urandom);
            fr_extra = -1;
            for (int i = 0; i < NV; i++) begin
                fr_s[i]  = SW'($urandom);
                fr_s2[i] = SW'($urandom);
                fr_d[i]  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
                fr_d2[i] = ($urandom_range(0, 3) == 0 && fr_d[i] >= 0) ? fr_d[i] + int'($urandom_range(1, 3)) : -1;
            end
            run_frame("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_mask();
        test_reset_mid();
        test_overwrite();
        test_timeout();
        test_overrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
